// File: rtl/ser_tx_seq.sv
// Parallel-to-serial frame transmitter: accepts a (BIT_WIDTH+1)-bit word on a valid/ready
// handshake and shifts it out LSB first, each bit held for BIT_PERIOD clock cycles.
module ser_tx_seq #(
    parameter int unsigned BIT_WIDTH  = 8,
    parameter int unsigned BIT_PERIOD = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BIT_WIDTH:0] in_data,
    output logic               ser_out,
    output logic               ser_valid,
    output logic               frame_start,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned CntW = $clog2(BIT_WIDTH + 1);
    localparam int unsigned DivW = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(BIT_WIDTH);
    localparam logic [DivW-1:0] DivLast = DivW'(BIT_PERIOD - 1);

    typedef enum logic {
        StIdle,
        StShift
    } state_t;

    state_t              state_q;
    logic [BIT_WIDTH:0]  sreg_q;
    logic [CntW-1:0]     bit_cnt_q;
    logic [DivW-1:0]     div_cnt_q;
    logic                frame_start_q;
    logic                frame_done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            sreg_q        <= '0;
            bit_cnt_q     <= '0;
            div_cnt_q     <= '0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        sreg_q        <= in_data;
                        bit_cnt_q     <= '0;
                        div_cnt_q     <= '0;
                        state_q       <= StShift;
                        frame_start_q <= 1'b1;
                    end
                end
                StShift: begin
                    if (div_cnt_q == DivLast) begin
                        div_cnt_q <= '0;
                        if (bit_cnt_q == CntLast) begin
                            state_q      <= StIdle;
                            frame_done_q <= 1'b1;
                        end else begin
                            sreg_q    <= {1'b0, sreg_q[BIT_WIDTH:1]};
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + DivW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Gate with state so a stale sreg bit never leaks out while idle.
    assign in_ready    = (state_q == StIdle);
    assign busy        = (state_q == StShift);
    assign ser_valid   = (state_q == StShift);
    assign ser_out     = (state_q == StShift) & sreg_q[0];
    assign frame_start = frame_start_q;
    assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_ser_tx_seq.sv
// Directed bench for ser_tx_seq: a default instance (BIT_PERIOD=4) and a BIT_PERIOD=1 instance.
module tb_ser_tx_seq;

    logic       clk;
    logic       rst;
    logic       in_valid, in_valid1;
    logic [8:0] in_data, in_data1;
    logic       in_ready, ser_out, ser_valid, frame_start, frame_done, busy;
    logic       in_ready1, ser_out1, ser_valid1, frame_start1, frame_done1, busy1;

    int tests_run = 0;
    int tests_failed = 0;
    logic exp_q[$];

    ser_tx_seq #(.BIT_WIDTH(8), .BIT_PERIOD(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .ser_out     (ser_out),
        .ser_valid   (ser_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .busy        (busy)
    );

    ser_tx_seq #(.BIT_WIDTH(8), .BIT_PERIOD(1)) dut1 (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid1),
        .in_ready    (in_ready1),
        .in_data     (in_data1),
        .ser_out     (ser_out1),
        .ser_valid   (ser_valid1),
        .frame_start (frame_start1),
        .frame_done  (frame_done1),
        .busy        (busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake one word into dut and check every SHIFT cycle against the scoreboard.
    // Returns at the frame_done cycle; hold keeps in_valid high, noise offers 9'h155 mid-frame.
    task automatic send_frame(input logic [8:0] data, input bit hold, input bit noise);
        int   waited = 0;
        logic exp_bit;
        while (!in_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        check("ready_before_send", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        in_data  = data;
        for (int i = 0; i < 9; i++) exp_q.push_back(data[i]);
        @(negedge clk);
        check("in_ready_low_in_shift", {31'd0, in_ready}, 32'd0);
        check("busy_in_shift", {31'd0, busy}, 32'd1);
        if (noise) in_data = 9'h155;
        in_valid = hold | noise;
        for (int b = 0; b < 9; b++) begin
            exp_bit = exp_q.pop_front();
            for (int c = 0; c < 4; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                check($sformatf("ser_out_b%0d_c%0d", b, c), {31'd0, ser_out}, {31'd0, exp_bit});
                check("ser_valid", {31'd0, ser_valid}, 32'd1);
                check("frame_start", {31'd0, frame_start}, (b == 0 && c == 0) ? 32'd1 : 32'd0);
                check("frame_done_early", {31'd0, frame_done}, 32'd0);
            end
        end
        in_valid = hold;
        in_data  = data;
        @(negedge clk);
        check("frame_done_pulse", {31'd0, frame_done}, 32'd1);
        check("in_ready_at_done", {31'd0, in_ready}, 32'd1);
        check("ser_valid_at_done", {31'd0, ser_valid}, 32'd0);
        check("ser_out_at_done", {31'd0, ser_out}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_bit;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_valid1 = 1'b0;
        in_data1  = '0;
        repeat (3) @(negedge clk);
        check("reset_ser_valid", {31'd0, ser_valid}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", {31'd0, in_ready}, 32'd1);
        check("reset_ser_out", {31'd0, ser_out}, 32'd0);

        // Single frame, then a one-cycle frame_done pulse
        send_frame(9'h1A5, 1'b0, 1'b0);
        @(negedge clk);
        check("frame_done_one_cycle", {31'd0, frame_done}, 32'd0);
        check("idle_after_frame", {31'd0, busy}, 32'd0);

        // Back-to-back frames with in_valid held high: one IDLE cycle between them
        send_frame(9'h0FF, 1'b1, 1'b0);
        send_frame(9'h100, 1'b0, 1'b0);
        @(negedge clk);

        // Word offered while busy is ignored
        send_frame(9'h0C3, 1'b0, 1'b1);
        @(negedge clk);
        check("no_accept_stays_idle", {31'd0, busy}, 32'd0);

        // Mid-frame reset at the first cycle of bit 4
        in_valid = 1'b1;
        in_data  = 9'h1A5;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        check("pre_reset_bit4", {31'd0, ser_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_reset_ser_out", {31'd0, ser_out}, 32'd0);
        check("mid_reset_ser_valid", {31'd0, ser_valid}, 32'd0);
        check("mid_reset_frame_start", {31'd0, frame_start}, 32'd0);
        check("mid_reset_frame_done", {31'd0, frame_done}, 32'd0);
        check("mid_reset_busy", {31'd0, busy}, 32'd0);
        check("mid_reset_in_ready", {31'd0, in_ready}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check("no_done_after_abort", {31'd0, frame_done}, 32'd0);
            check("no_resume_after_abort", {31'd0, ser_valid}, 32'd0);
        end

        // Reset and handshake at the same edge
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 9'h0AA;
        @(negedge clk);
        check("rst_hs_busy", {31'd0, busy}, 32'd0);
        check("rst_hs_frame_start", {31'd0, frame_start}, 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("rst_hs_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_hs_ser_valid", {31'd0, ser_valid}, 32'd0);

        // BIT_PERIOD=1 instance: one bit per cycle, frame_done at cycle 10
        in_valid1 = 1'b1;
        in_data1  = 9'h001;
        for (int i = 0; i < 9; i++) exp_q.push_back(in_data1[i]);
        @(negedge clk);
        in_valid1 = 1'b0;
        check("bp1_frame_start", {31'd0, frame_start1}, 32'd1);
        for (int b = 0; b < 9; b++) begin
            if (b != 0) @(negedge clk);
            exp_bit = exp_q.pop_front();
            check($sformatf("bp1_ser_out_b%0d", b), {31'd0, ser_out1}, {31'd0, exp_bit});
            check("bp1_ser_valid", {31'd0, ser_valid1}, 32'd1);
            check("bp1_no_early_done", {31'd0, frame_done1}, 32'd0);
        end
        @(negedge clk);
        check("bp1_frame_done", {31'd0, frame_done1}, 32'd1);
        check("bp1_in_ready", {31'd0, in_ready1}, 32'd1);
        @(negedge clk);
        check("bp1_done_one_cycle", {31'd0, frame_done1}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
